pipe_ffr: RTL and testbench



---
 rtl/pipe_ffr.sv | 95 +++++++++
 tb/tb_pipe_ffr.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ffr.sv
// Elastic WIDTH-bit pipeline register with DEPTH stages, valid/ready handshake,
// Q/Qbar outputs and a parameter-selected active clock edge.
module pipe_ffr #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter int               EDGE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           D,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Qbar,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int OCCW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] rdy;
  logic             rdyAcc;

  // A stage can load if it is empty or any stage downstream of it will move.
  always_comb begin
    rdyAcc = out_ready;
    rdy    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdyAcc = rdyAcc | ~v_q[k];
      rdy[k] = rdyAcc;
    end
  end

  assign in_ready = rdy[0] & ~flush;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (rdy[0]) begin
        v_d[0] = in_valid & in_ready;
        if (in_valid & in_ready) data_d[0] = D;
      end
      // Bubbles advance the valid flag but never overwrite stored data.
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) data_d[k] = data_q[k-1];
        end
      end
    end
  end

  generate
    if (EDGE == 0) begin : g_rise
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VAL;
        end else begin
          v_q    <= v_d;
          data_q <= data_d;
        end
      end
    end else begin : g_fall
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VAL;
        end else begin
          v_q    <= v_d;
          data_q <= data_d;
        end
      end
    end
  endgenerate

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OCCW'(v_q[k]);
  end

  assign Q         = data_q[DEPTH-1];
  assign Qbar      = ~data_q[DEPTH-1];
  assign out_valid = v_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_ffr.sv
// Directed bench for pipe_ffr: a rising-edge instance and a falling-edge
// instance, both WIDTH=4, DEPTH=2, RESET_VAL=4'hA.
module tb_pipe_ffr;

  localparam logic [3:0] RV = 4'hA;

  logic clk = 1'b0;
  logic clkEn = 1'b0;
  logic rst = 1'b0;

  logic       flush0 = 1'b0, inValid0 = 1'b0, outReady0 = 1'b1;
  logic [3:0] d0 = '0;
  logic       inReady0, outValid0;
  logic [3:0] q0, qbar0;
  logic [1:0] occ0;

  logic       flush1 = 1'b0, inValid1 = 1'b0, outReady1 = 1'b1;
  logic [3:0] d1 = '0;
  logic       inReady1, outValid1;
  logic [3:0] q1, qbar1;
  logic [1:0] occ1;

  int passCount = 0;
  int checkCount = 0;

  always begin
    #5;
    if (clkEn) clk = ~clk;
  end

  pipe_ffr #(.WIDTH(4), .DEPTH(2), .EDGE(0), .RESET_VAL(RV)) u0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(inValid0), .in_ready(inReady0),
    .D(d0), .out_valid(outValid0), .out_ready(outReady0), .Q(q0), .Qbar(qbar0), .occ(occ0)
  );

  pipe_ffr #(.WIDTH(4), .DEPTH(2), .EDGE(1), .RESET_VAL(RV)) u1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(inValid1), .in_ready(inReady1),
    .D(d1), .out_valid(outValid1), .out_ready(outReady1), .Q(q1), .Qbar(qbar1), .occ(occ1)
  );

  task automatic step0();
    @(posedge clk);
    #1;
  endtask

  task automatic step1();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    checkCount++; if (q0 !== RV) $display("[TB] FAIL reset_q0: got %h expected %h", q0, RV); else passCount++;
    checkCount++; if (qbar0 !== 4'h5) $display("[TB] FAIL reset_qbar0: got %h expected 5", qbar0); else passCount++;
    checkCount++; if (outValid0 !== 1'b0) $display("[TB] FAIL reset_valid0: got %b expected 0", outValid0); else passCount++;
    checkCount++; if (occ0 !== 2'd0) $display("[TB] FAIL reset_occ0: got %0d expected 0", occ0); else passCount++;
    checkCount++; if (inReady0 !== 1'b1) $display("[TB] FAIL reset_inready0: got %b expected 1", inReady0); else passCount++;
    checkCount++; if (q1 !== RV || occ1 !== 2'd0) $display("[TB] FAIL reset_u1: got q=%h occ=%0d expected q=a occ=0", q1, occ1); else passCount++;
    flush0 = 1'b1;
    #1;
    checkCount++; if (inReady0 !== 1'b0) $display("[TB] FAIL reset_flush_inready: got %b expected 0", inReady0); else passCount++;
    flush0 = 1'b0;
    clkEn = 1'b1;
    step0();
    step0();
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [3:0] expQ;
    int expOcc;
    logic expValid;
    outReady0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      inValid0 = (i < 4);
      d0 = (i < 4) ? 4'(i + 1) : 4'h0;
      checkCount++; if (inReady0 !== 1'b1) $display("[TB] FAIL stream_inready%0d: got %b expected 1", i, inReady0); else passCount++;
      step0();
      expValid = (i >= 1 && i <= 4);
      expQ = (i == 0) ? RV : ((i > 4) ? 4'd4 : 4'(i));
      expOcc = int'(i < 4) + int'(i >= 1 && i <= 4);
      checkCount++; if (outValid0 !== expValid) $display("[TB] FAIL stream_valid%0d: got %b expected %b", i, outValid0, expValid); else passCount++;
      checkCount++; if (q0 !== expQ || qbar0 !== ~expQ) $display("[TB] FAIL stream_q%0d: got q=%h qbar=%h expected q=%h", i, q0, qbar0, expQ); else passCount++;
      checkCount++; if (occ0 !== 2'(expOcc)) $display("[TB] FAIL stream_occ%0d: got %0d expected %0d", i, occ0, expOcc); else passCount++;
    end
    inValid0 = 1'b0;
  endtask

  task automatic test_backpressure();
    outReady0 = 1'b1;
    inValid0 = 1'b1;
    d0 = 4'd5;
    step0();
    d0 = 4'd6;
    step0();
    inValid0 = 1'b0;
    outReady0 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkCount++; if (occ0 !== 2'd2) $display("[TB] FAIL bp_occ%0d: got %0d expected 2", i, occ0); else passCount++;
      checkCount++; if (inReady0 !== 1'b0) $display("[TB] FAIL bp_inready%0d: got %b expected 0", i, inReady0); else passCount++;
      checkCount++; if (q0 !== 4'd5 || outValid0 !== 1'b1) $display("[TB] FAIL bp_hold%0d: got q=%h v=%b expected q=5 v=1", i, q0, outValid0); else passCount++;
      step0();
    end
    outReady0 = 1'b1;
    #1;
    checkCount++; if (inReady0 !== 1'b1) $display("[TB] FAIL bp_release_inready: got %b expected 1", inReady0); else passCount++;
    step0();
    checkCount++; if (q0 !== 4'd6 || outValid0 !== 1'b1 || occ0 !== 2'd1) $display("[TB] FAIL bp_second: got q=%h v=%b occ=%0d expected q=6 v=1 occ=1", q0, outValid0, occ0); else passCount++;
    step0();
    checkCount++; if (outValid0 !== 1'b0 || occ0 !== 2'd0) $display("[TB] FAIL bp_nodup: got v=%b occ=%0d expected v=0 occ=0", outValid0, occ0); else passCount++;
  endtask

  task automatic test_bubble();
    logic [2:0] expValid;
    logic [3:0] expQ [3];
    expValid = 3'b101;
    expQ[0] = 4'd7; expQ[1] = 4'd7; expQ[2] = 4'd8;
    outReady0 = 1'b1;
    inValid0 = 1'b1;
    d0 = 4'd7;
    step0();
    for (int i = 0; i < 3; i++) begin
      inValid0 = (i == 1);
      d0 = (i == 1) ? 4'd8 : 4'd0;
      step0();
      checkCount++; if (outValid0 !== expValid[2-i]) $display("[TB] FAIL bubble_valid%0d: got %b expected %b", i, outValid0, expValid[2-i]); else passCount++;
      checkCount++; if (q0 !== expQ[i]) $display("[TB] FAIL bubble_q%0d: got %h expected %h", i, q0, expQ[i]); else passCount++;
    end
    inValid0 = 1'b0;
    step0();
  endtask

  task automatic test_flush();
    outReady0 = 1'b0;
    inValid0 = 1'b1;
    d0 = 4'd3;
    step0();
    d0 = 4'd4;
    step0();
    checkCount++; if (occ0 !== 2'd2) $display("[TB] FAIL flush_full: got occ=%0d expected 2", occ0); else passCount++;
    flush0 = 1'b1;
    d0 = 4'd9;
    #1;
    checkCount++; if (inReady0 !== 1'b0) $display("[TB] FAIL flush_inready: got %b expected 0", inReady0); else passCount++;
    step0();
    flush0 = 1'b0;
    inValid0 = 1'b0;
    checkCount++; if (occ0 !== 2'd0 || outValid0 !== 1'b0) $display("[TB] FAIL flush_occ: got occ=%0d v=%b expected occ=0 v=0", occ0, outValid0); else passCount++;
    outReady0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step0();
      checkCount++; if (outValid0 !== 1'b0 || q0 !== 4'd3) $display("[TB] FAIL flush_drain%0d: got v=%b q=%h expected v=0 q=3", i, outValid0, q0); else passCount++;
    end
  endtask

  task automatic test_edge1();
    logic [3:0] expQ;
    int expOcc;
    int prevOcc;
    logic expValid;
    logic prevValid;
    prevOcc = 0;
    prevValid = 1'b0;
    outReady1 = 1'b1;
    step1();
    for (int i = 0; i < 6; i++) begin
      inValid1 = (i < 4);
      d1 = (i < 4) ? 4'(i + 1) : 4'h0;
      @(posedge clk);
      #1;
      checkCount++; if (occ1 !== 2'(prevOcc) || outValid1 !== prevValid) $display("[TB] FAIL edge1_rise%0d: got occ=%0d v=%b expected occ=%0d v=%b", i, occ1, outValid1, prevOcc, prevValid); else passCount++;
      step1();
      expValid = (i >= 1 && i <= 4);
      expQ = (i == 0) ? RV : ((i > 4) ? 4'd4 : 4'(i));
      expOcc = int'(i < 4) + int'(i >= 1 && i <= 4);
      checkCount++; if (outValid1 !== expValid || q1 !== expQ || qbar1 !== ~expQ) $display("[TB] FAIL edge1_fall%0d: got v=%b q=%h expected v=%b q=%h", i, outValid1, q1, expValid, expQ); else passCount++;
      checkCount++; if (occ1 !== 2'(expOcc)) $display("[TB] FAIL edge1_occ%0d: got %0d expected %0d", i, occ1, expOcc); else passCount++;
      prevOcc = expOcc;
      prevValid = expValid;
    end
    inValid1 = 1'b1;
    d1 = 4'd5;
    step1();
    step1();
    checkCount++; if (occ1 !== 2'd2) $display("[TB] FAIL edge1_prefill: got occ=%0d expected 2", occ1); else passCount++;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkCount++; if (occ1 !== 2'd0 || outValid1 !== 1'b0 || q1 !== RV) $display("[TB] FAIL edge1_async_reset: got occ=%0d v=%b q=%h expected occ=0 v=0 q=a", occ1, outValid1, q1); else passCount++;
    inValid1 = 1'b0;
    rst = 1'b0;
    step1();
  endtask

  initial begin
    $display("[TB] starting pipe_ffr bench");
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_edge1();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
